rdy_vld_rr_arb: RTL and testbench

RDY_VLD_RR_ARB -- requirements
Module: rdy_vld_rr_arb

---
 rtl/rdy_vld_rr_arb.sv | 157 +++++++++++++++
 tb/tb_rdy_vld_rr_arb.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rdy_vld_rr_arb.sv
// rdy_vld_rr_arb
//   Round-robin arbiter that merges N ready/valid packet streams into one.
//   The arbiter grants whole packets. Once it grants a requester, that grant
//   stays in place until the beat carrying src_last has transferred. The
//   datapath and the ready return path are purely combinational, so they add
//   no latency.
//
// Ports
//   clk       : single clock, rising-edge
//   rst_n     : synchronous active-low reset
//   src_vld   : [N] per-requester valid
//   src_data  : [N*DATA_W] per-requester payload, requester i at [i*DATA_W +: DATA_W]
//   src_last  : [N] per-requester end-of-packet, qualified by src_vld
//   src_rdy   : [N] per-requester ready (only the granted bit can be high)
//   dst_vld   : merged valid
//   dst_data  : [DATA_W] merged payload
//   dst_last  : merged end-of-packet
//   dst_rdy   : downstream ready
//   dst_id    : [IDW] index of the currently granted requester
//   busy      : high while a packet holds the grant (LOCKED)
module rdy_vld_rr_arb #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int IDW    = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          src_vld,
  input  logic [N*DATA_W-1:0]   src_data,
  input  logic [N-1:0]          src_last,
  output logic [N-1:0]          src_rdy,
  output logic                  dst_vld,
  output logic [DATA_W-1:0]     dst_data,
  output logic                  dst_last,
  input  logic                  dst_rdy,
  output logic [IDW-1:0]        dst_id,
  output logic                  busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] gnt_q, gnt_d;

  logic [IDW-1:0] scan_g;
  logic           scan_hit;
  logic [IDW-1:0] g;
  logic           sel_vld;
  logic           sel_last;
  logic [DATA_W-1:0] sel_data;
  logic           xfer;

  // Increment modulo N. The explicit compare handles N values that are not
  // a power of two, where the plain binary add would not wrap to 0.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
    if (v == IDW'(N - 1)) begin
      return '0;
    end
    return v + 1'b1;
  endfunction

  // Rotating priority scan: pick the first valid requester starting at
  // rr_ptr. If nothing is valid, the grant rests on rr_ptr.
  always_comb begin
    int idx;
    scan_g   = rr_ptr_q;
    scan_hit = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!scan_hit && src_vld[IDW'(idx)]) begin
        scan_hit = 1'b1;
        scan_g   = IDW'(idx);
      end
    end
  end

  // While LOCKED, the stored grant wins and new requests are ignored.
  assign g = (state_q == LOCKED) ? gnt_q : scan_g;

  // Select the granted requester's beat.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (IDW'(i) == g) begin
        sel_data = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_vld  = src_vld[g];
  assign sel_last = src_last[g];
  assign xfer     = sel_vld & dst_rdy;

  // Outputs are gated with rst_n so that nothing handshakes while reset is
  // held, whatever the registered state happens to be.
  assign dst_vld  = rst_n & sel_vld;
  assign dst_data = sel_data;
  assign dst_last = sel_last;
  assign dst_id   = g;
  assign busy     = rst_n & (state_q == LOCKED);

  // Ready goes back only to the granted requester. In IDLE with no request
  // pending, the grant is only a resting pointer and nobody gets ready.
  always_comb begin
    src_rdy = '0;
    if (rst_n && ((state_q == LOCKED) || scan_hit)) begin
      src_rdy[g] = dst_rdy;
    end
  end

  // Next-state logic. A granted beat that stalls, or that is not the last
  // beat, locks the grant so the beat on offer cannot be re-arbitrated away.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          if (xfer && sel_last) begin
            rr_ptr_d = wrap_inc(g);
          end else begin
            state_d = LOCKED;
            gnt_d   = g;
          end
        end
      end
      LOCKED: begin
        if (xfer && sel_last) begin
          state_d  = IDLE;
          rr_ptr_d = wrap_inc(gnt_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
    end
  end

endmodule

// File: tb/tb_rdy_vld_rr_arb.sv
// tb_rdy_vld_rr_arb
//   Directed, table-driven bench for rdy_vld_rr_arb with N=4 and DATA_W=8.
//   Each record holds one cycle of inputs and the outputs expected in that
//   same cycle, before the next rising edge. Records with full=0 are reset
//   cycles, where only the handshake outputs are defined.
module tb_rdy_vld_rr_arb;

  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int IDW    = 2;

  logic                clk;
  logic                rst_n;
  logic [N-1:0]        src_vld;
  logic [N*DATA_W-1:0] src_data;
  logic [N-1:0]        src_last;
  logic [N-1:0]        src_rdy;
  logic                dst_vld;
  logic [DATA_W-1:0]   dst_data;
  logic                dst_last;
  logic                dst_rdy;
  logic [IDW-1:0]      dst_id;
  logic                busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst_n;
    logic [3:0]  vld;
    logic [31:0] data;
    logic [3:0]  last;
    logic        rdy;
    logic        full;
    logic        e_vld;
    logic [7:0]  e_data;
    logic        e_last;
    logic [1:0]  e_id;
    logic [3:0]  e_src_rdy;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  rdy_vld_rr_arb #(.N(N), .DATA_W(DATA_W), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_vld  (src_vld),
    .src_data (src_data),
    .src_last (src_last),
    .src_rdy  (src_rdy),
    .dst_vld  (dst_vld),
    .dst_data (dst_data),
    .dst_last (dst_last),
    .dst_rdy  (dst_rdy),
    .dst_id   (dst_id),
    .busy     (busy)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [31:0] d,
                              input logic [3:0] l, input logic dr, input logic f,
                              input logic ev, input logic [7:0] ed, input logic el,
                              input logic [1:0] eid, input logic [3:0] er, input logic eb);
    vec_t t;
    t.rst_n = r;  t.vld = v;  t.data = d;  t.last = l;  t.rdy = dr;  t.full = f;
    t.e_vld = ev; t.e_data = ed; t.e_last = el; t.e_id = eid; t.e_src_rdy = er; t.e_busy = eb;
    return t;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst_n    = v.rst_n;
    src_vld  = v.vld;
    src_data = v.data;
    src_last = v.last;
    dst_rdy  = v.rdy;
  endtask

  task automatic cmp(input string tag, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s: got %0h expected %0h", tag, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    cmp(tag, "src_rdy", 32'(src_rdy), 32'(v.e_src_rdy));
    cmp(tag, "dst_vld", 32'(dst_vld), 32'(v.e_vld));
    cmp(tag, "busy",    32'(busy),    32'(v.e_busy));
    if (v.full) begin
      cmp(tag, "dst_data", 32'(dst_data), 32'(v.e_data));
      cmp(tag, "dst_last", 32'(dst_last), 32'(v.e_last));
      cmp(tag, "dst_id",   32'(dst_id),   32'(v.e_id));
    end
  endtask

  // Drive one cycle, sample mid-cycle, and then step past the next rising edge.
  task automatic runCycle(input string tag, input vec_t v);
    applyStimulus(v);
    #3;
    checkOutput(tag, v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t h;
    // Reset cycles: no handshake, whatever the inputs are.
    vecs.push_back(mk(0, 4'b0000, 32'h0,        4'b0000, 1, 0, 0, 8'h00, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1111, 32'h44332211, 4'b1111, 1, 0, 0, 8'h00, 0, 0, 4'b0000, 0));
    // Sparse requesters 1 and 3 alternate, and the pointer wraps 3 -> 0.
    vecs.push_back(mk(1, 4'b1010, 32'h44332211, 4'b1111, 1, 1, 1, 8'h22, 1, 1, 4'b0010, 0));
    vecs.push_back(mk(1, 4'b1010, 32'h44332211, 4'b1111, 1, 1, 1, 8'h44, 1, 3, 4'b1000, 0));
    vecs.push_back(mk(1, 4'b1010, 32'h44332211, 4'b1111, 1, 1, 1, 8'h22, 1, 1, 4'b0010, 0));
    // Reset again, then all four requesters valid gives fair rotation.
    vecs.push_back(mk(0, 4'b1111, 32'h44332211, 4'b1111, 1, 0, 0, 8'h00, 0, 0, 4'b0000, 0));
    for (int i = 0; i < 8; i++) begin
      int k;
      k = i % 4;
      vecs.push_back(mk(1, 4'b1111, 32'h44332211, 4'b1111, 1, 1, 1, 8'(8'h11 * (k + 1)), 1,
                        2'(k), 4'(1 << k), 0));
    end
    // Move the pointer to 2, then run a 3-beat packet from 2 while 0 waits.
    vecs.push_back(mk(1, 4'b0010, 32'h00002200, 4'b0010, 1, 1, 1, 8'h22, 1, 1, 4'b0010, 0));
    vecs.push_back(mk(1, 4'b0101, 32'h00AA0011, 4'b0001, 1, 1, 1, 8'hAA, 0, 2, 4'b0100, 0));
    vecs.push_back(mk(1, 4'b0101, 32'h00BB0011, 4'b0001, 1, 1, 1, 8'hBB, 0, 2, 4'b0100, 1));
    vecs.push_back(mk(1, 4'b0101, 32'h00CC0011, 4'b0101, 1, 1, 1, 8'hCC, 1, 2, 4'b0100, 1));
    vecs.push_back(mk(1, 4'b0001, 32'h00000011, 4'b0001, 1, 1, 1, 8'h11, 1, 0, 4'b0001, 0));
    // Requester 1 stalls by dst_rdy. Requester 0 arrives, but it must not steal the grant.
    vecs.push_back(mk(1, 4'b0010, 32'h00005500, 4'b0010, 0, 1, 1, 8'h55, 1, 1, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0011, 32'h00005566, 4'b0011, 0, 1, 1, 8'h55, 1, 1, 4'b0000, 1));
    vecs.push_back(mk(1, 4'b0011, 32'h00005566, 4'b0011, 0, 1, 1, 8'h55, 1, 1, 4'b0000, 1));
    vecs.push_back(mk(1, 4'b0011, 32'h00005566, 4'b0011, 1, 1, 1, 8'h55, 1, 1, 4'b0010, 1));
    vecs.push_back(mk(1, 4'b0001, 32'h00000066, 4'b0001, 1, 1, 1, 8'h66, 1, 0, 4'b0001, 0));
    // Requester 3 has a two-cycle bubble mid-packet. Requester 0 waits until the packet is done.
    vecs.push_back(mk(1, 4'b1001, 32'hD1000077, 4'b0001, 1, 1, 1, 8'hD1, 0, 3, 4'b1000, 0));
    vecs.push_back(mk(1, 4'b0001, 32'h00000077, 4'b0001, 1, 1, 0, 8'h00, 0, 3, 4'b1000, 1));
    vecs.push_back(mk(1, 4'b0001, 32'h00000077, 4'b0001, 1, 1, 0, 8'h00, 0, 3, 4'b1000, 1));
    vecs.push_back(mk(1, 4'b1001, 32'hD2000077, 4'b1001, 1, 1, 1, 8'hD2, 1, 3, 4'b1000, 1));
    vecs.push_back(mk(1, 4'b0001, 32'h00000077, 4'b0001, 1, 1, 1, 8'h77, 1, 0, 4'b0001, 0));
    // Lock on requester 2, reset mid-packet, then restart at requester 0.
    vecs.push_back(mk(1, 4'b0101, 32'h00880099, 4'b0000, 1, 1, 1, 8'h88, 0, 2, 4'b0100, 0));
    vecs.push_back(mk(1, 4'b0101, 32'h00880099, 4'b0000, 1, 1, 1, 8'h88, 0, 2, 4'b0100, 1));
    vecs.push_back(mk(0, 4'b0101, 32'h00880099, 4'b0000, 1, 0, 0, 8'h00, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0101, 32'h00880099, 4'b0000, 1, 1, 1, 8'h99, 0, 0, 4'b0001, 0));
    vecs.push_back(mk(1, 4'b0001, 32'h00000099, 4'b0001, 1, 1, 1, 8'h99, 1, 0, 4'b0001, 1));
    // IDLE with nothing valid: the grant rests on the pointer and no ready is returned.
    vecs.push_back(mk(1, 4'b0000, 32'h00000000, 4'b0000, 1, 1, 0, 8'h00, 0, 1, 4'b0000, 0));

    applyStimulus(vecs[0]);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      runCycle($sformatf("vec%0d", i), vecs[i]);
    end

    // Hand-written sequence: a single-beat packet from requester 3 stalls,
    // so it locks. On release, the pointer wraps from 3 to 0.
    h = mk(1, 4'b1000, 32'hE1000000, 4'b1000, 0, 1, 1, 8'hE1, 1, 3, 4'b0000, 0);
    runCycle("wrap_stall", h);
    h = mk(1, 4'b1000, 32'hE1000000, 4'b1000, 1, 1, 1, 8'hE1, 1, 3, 4'b1000, 1);
    runCycle("wrap_release", h);
    h = mk(1, 4'b1001, 32'hE10000F0, 4'b1001, 1, 1, 1, 8'hF0, 1, 0, 4'b0001, 0);
    runCycle("wrap_next", h);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
